// File: rtl/pwm_breathe_pkg.sv
// Shared types and helpers for the multi-channel breathing PWM driver.
package pwm_breathe_pkg;

  typedef enum logic [2:0] {IDLE, OFFSET, RISE, HIGH, FALL, LOW} breathe_state_t;

  // Full-scale duty for an R-bit generator: 2^R (needs R+1 bits).
  function automatic int unsigned duty_max(input int unsigned r);
    return 32'd1 << r;
  endfunction

endpackage

// File: rtl/pwm_enhanced.sv
// PWM generator with prescaler: output high while the R-bit phase counter is below duty.
// duty = 2^R gives a constantly high output; the phase counter advances every dvsr+1 clocks.
module pwm_enhanced #(
  parameter int R  = 8,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] dvsr,
  input  logic [R:0]    duty,
  output logic          pwm_out
);

  logic [DW-1:0] q_q, q_d;
  logic [R-1:0]  d_q, d_d;
  logic          pwm_q, pwm_d;

  always_comb begin
    q_d   = (q_q == dvsr) ? '0 : q_q + DW'(1);
    d_d   = (q_q == dvsr) ? d_q + R'(1) : d_q;
    pwm_d = ({1'b0, d_q} < duty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q   <= '0;
      d_q   <= '0;
      pwm_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      d_q   <= d_d;
      pwm_q <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;

endmodule

// File: rtl/pwm_breathe_multi.sv
// N-channel breathing LED driver: per-channel rise/high/fall/low FSM with start offsets,
// paced by one shared step prescaler, each channel feeding its own PWM generator.
module pwm_breathe_multi
  import pwm_breathe_pkg::*;
#(
  parameter int R      = 8,
  parameter int N_CH   = 3,
  parameter int DVSR   = 4882,
  parameter int CNT_W  = 32,
  parameter int HOLD_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   one_shot,
  input  logic [CNT_W-1:0]       step_thresh,
  input  logic [HOLD_W-1:0]      hold_high,
  input  logic [HOLD_W-1:0]      hold_low,
  input  logic [N_CH*HOLD_W-1:0] offset,
  output logic [N_CH-1:0]        pwm_out,
  output logic [N_CH*(R+1)-1:0]  duty,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned DUTY_MAX_I = duty_max(R);
  localparam logic [R:0]  DUTY_MAX   = DUTY_MAX_I[R:0];
  localparam logic [R:0]  DUTY_TOP   = DUTY_MAX - (R+1)'(1);

  logic [CNT_W-1:0]       cnt_q, cnt_d, thresh_q, thresh_d, thr;
  logic [HOLD_W-1:0]      hh_q, hh_d, hl_q, hl_d;
  logic [N_CH*HOLD_W-1:0] off_q, off_d;
  logic                   os_q, os_d, fin_q, fin_d, done_q, done_d;
  logic                   tick, start;
  logic [N_CH-1:0]        ch_busy, ch_busy_d, comp_ch;

  // Restart is held off for the cycle after completion so done is seen before a new run.
  assign busy  = |ch_busy;
  assign thr   = (thresh_q == '0) ? CNT_W'(1) : thresh_q;
  assign tick  = busy && (cnt_q == thr - CNT_W'(1));
  assign start = en && !busy && !fin_q;
  assign fin_d = (|comp_ch) && !(|ch_busy_d);

  always_comb begin
    cnt_d    = (!busy || tick) ? '0 : cnt_q + CNT_W'(1);
    thresh_d = thresh_q;
    hh_d     = hh_q;
    hl_d     = hl_q;
    off_d    = off_q;
    os_d     = os_q;
    done_d   = fin_q;
    if (start) begin
      thresh_d = step_thresh;
      hh_d     = hold_high;
      hl_d     = hold_low;
      off_d    = offset;
      os_d     = one_shot;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q    <= '0;
      thresh_q <= '0;
      hh_q     <= '0;
      hl_q     <= '0;
      off_q    <= '0;
      os_q     <= 1'b0;
      fin_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      thresh_q <= thresh_d;
      hh_q     <= hh_d;
      hl_q     <= hl_d;
      off_q    <= off_d;
      os_q     <= os_d;
      fin_q    <= fin_d;
      done_q   <= done_d;
    end
  end

  assign done = done_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    breathe_state_t     state_q, state_d;
    logic [R:0]         duty_q, duty_d;
    logic [HOLD_W-1:0]  hold_q, hold_d, hold_inc, off_i;
    logic               comp;

    assign off_i    = off_q[i*HOLD_W +: HOLD_W];
    assign hold_inc = hold_q + HOLD_W'(1);

    always_comb begin
      state_d = state_q;
      duty_d  = duty_q;
      hold_d  = hold_q;
      comp    = 1'b0;
      if (state_q != IDLE && !en) begin
        state_d = IDLE;
        duty_d  = '0;
        hold_d  = '0;
      end else begin
        case (state_q)
          IDLE: if (start) begin
            state_d = OFFSET;
            duty_d  = '0;
            hold_d  = '0;
          end
          OFFSET: if (off_i == '0 || (tick && hold_inc == off_i)) begin
            state_d = RISE;
            hold_d  = '0;
          end else if (tick) begin
            hold_d = hold_inc;
          end
          RISE: if (tick) begin
            if (duty_q < DUTY_MAX) duty_d = duty_q + (R+1)'(1);
            if (duty_q >= DUTY_TOP) begin
              state_d = HIGH;
              hold_d  = '0;
            end
          end
          HIGH: if (hh_q == '0 || (tick && hold_inc == hh_q)) begin
            state_d = FALL;
            hold_d  = '0;
          end else if (tick) begin
            hold_d = hold_inc;
          end
          FALL: if (tick) begin
            if (duty_q != '0) duty_d = duty_q - (R+1)'(1);
            if (duty_q <= (R+1)'(1)) begin
              state_d = LOW;
              hold_d  = '0;
            end
          end
          LOW: if (hl_q == '0 || (tick && hold_inc == hl_q)) begin
            hold_d  = '0;
            state_d = os_q ? IDLE : RISE;
            comp    = os_q;
          end else if (tick) begin
            hold_d = hold_inc;
          end
          default: begin
            state_d = IDLE;
            duty_d  = '0;
            hold_d  = '0;
          end
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        state_q <= IDLE;
        duty_q  <= '0;
        hold_q  <= '0;
      end else begin
        state_q <= state_d;
        duty_q  <= duty_d;
        hold_q  <= hold_d;
      end
    end

    assign ch_busy[i]           = (state_q != IDLE);
    assign ch_busy_d[i]         = (state_d != IDLE);
    assign comp_ch[i]           = comp;
    assign duty[i*(R+1) +: R+1] = duty_q;

    pwm_enhanced #(.R(R), .DW(CNT_W)) u_pwm (
      .clk     (clk),
      .rst     (~rst),
      .dvsr    (CNT_W'(DVSR)),
      .duty    (duty_q),
      .pwm_out (pwm_out[i])
    );
  end

endmodule

// File: tb/tb_pwm_breathe_multi.sv
// Directed bench for pwm_breathe_multi (R=4, DVSR=1, 3 channels): timing of ramps, holds,
// phasing, abort, boundary configs and config latching against hand-derived schedules.
module tb_pwm_breathe_multi;
  localparam int R = 4, N_CH = 3, DW = R + 1, HW = 16, CW = 32;

  logic               clk = 1'b0;
  logic               rst, en, one_shot;
  logic [CW-1:0]      step_thresh;
  logic [HW-1:0]      hold_high, hold_low;
  logic [N_CH*HW-1:0] offset;
  logic [N_CH-1:0]    pwm_out;
  logic [N_CH*DW-1:0] duty;
  logic               busy, done;

  int errors = 0;
  int checks = 0;
  int j_now  = 0;
  int done_cnt = 0;
  bit ovf = 1'b0;

  pwm_breathe_multi #(.R(R), .N_CH(N_CH), .DVSR(1), .CNT_W(CW), .HOLD_W(HW)) dut (
    .clk(clk), .rst(rst), .en(en), .one_shot(one_shot), .step_thresh(step_thresh),
    .hold_high(hold_high), .hold_low(hold_low), .offset(offset),
    .pwm_out(pwm_out), .duty(duty), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Counts done pulses and flags any duty above full scale (overflow or wrap-around).
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    for (int c = 0; c < N_CH; c++)
      if (duty[c*DW +: DW] > 5'd16) ovf = 1'b1;
  end

  function automatic logic [N_CH*DW-1:0] rep3(input int k);
    logic [DW-1:0] v;
    v = DW'(k);
    return {v, v, v};
  endfunction

  // ch0 duty j clocks after start with step_thresh=2, hold_high=1, hold_low=1.
  function automatic int g(input int j);
    int m;
    m = j % 68;
    if (m <= 33) return m / 2;
    return 16 - (m - 34) / 2;
  endfunction

  task automatic adv_to(input int target);
    while (j_now < target) begin
      @(negedge clk);
      j_now++;
    end
  endtask

  task automatic start_run();
    @(negedge clk);
    en = 1'b1;
    j_now = -1;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; one_shot = 1'b0; step_thresh = 32'd4;
    hold_high = 16'd1; hold_low = 16'd1; offset = '0;
    repeat (3) begin
      @(negedge clk);
      if (duty !== '0) begin $display("FAIL reset_duty: got %0h want 0", duty); errors++; end
      checks++;
      if (pwm_out !== '0) begin $display("FAIL reset_pwm: got %0b want 0", pwm_out); errors++; end
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        $display("FAIL reset_flags: busy=%b done=%b want 0 0", busy, done); errors++;
      end
      checks++;
    end
    rst = 1'b1; en = 1'b0;
    @(negedge clk);
    if (busy !== 1'b0) begin $display("FAIL idle_after_reset: busy=%b want 0", busy); errors++; end
    checks++;
  endtask

  task automatic test_one_shot();
    int base;
    step_thresh = 32'd4; hold_high = 16'd2; hold_low = 16'd1; offset = '0; one_shot = 1'b1;
    base = done_cnt;
    start_run();
    adv_to(0);
    if (busy !== 1'b1 || duty !== '0) begin
      $display("FAIL os_start: busy=%b duty=%0h want 1 0", busy, duty); errors++;
    end
    checks++;
    adv_to(3);
    if (duty !== rep3(0)) begin $display("FAIL os_j3: got %0h want %0h", duty, rep3(0)); errors++; end
    checks++;
    adv_to(4);
    if (duty !== rep3(1)) begin $display("FAIL os_j4: got %0h want %0h", duty, rep3(1)); errors++; end
    checks++;
    adv_to(63);
    if (duty !== rep3(15)) begin $display("FAIL os_j63: got %0h want %0h", duty, rep3(15)); errors++; end
    checks++;
    adv_to(64);
    if (duty !== rep3(16)) begin $display("FAIL os_j64: got %0h want %0h", duty, rep3(16)); errors++; end
    checks++;
    for (int k = 66; k <= 71; k++) begin
      adv_to(k);
      if (pwm_out !== 3'b111) begin $display("FAIL os_pwm_full j=%0d: got %b want 111", k, pwm_out); errors++; end
      checks++;
    end
    adv_to(72);
    if (duty !== rep3(16)) begin $display("FAIL os_j72: got %0h want %0h", duty, rep3(16)); errors++; end
    checks++;
    adv_to(76);
    if (duty !== rep3(15)) begin $display("FAIL os_j76: got %0h want %0h", duty, rep3(15)); errors++; end
    checks++;
    adv_to(135);
    if (duty !== rep3(1)) begin $display("FAIL os_j135: got %0h want %0h", duty, rep3(1)); errors++; end
    checks++;
    adv_to(136);
    if (duty !== rep3(0)) begin $display("FAIL os_j136: got %0h want %0h", duty, rep3(0)); errors++; end
    checks++;
    adv_to(139);
    if (busy !== 1'b1) begin $display("FAIL os_busy_low_hold: got %b want 1", busy); errors++; end
    checks++;
    adv_to(140);
    if (busy !== 1'b0 || done !== 1'b0) begin
      $display("FAIL os_end: busy=%b done=%b want 0 0", busy, done); errors++;
    end
    checks++;
    adv_to(141);
    if (done !== 1'b1) begin $display("FAIL os_done: got %b want 1", done); errors++; end
    checks++;
    en = 1'b0;
    adv_to(145);
    if (done_cnt - base !== 1) begin $display("FAIL os_done_count: got %0d want 1", done_cnt - base); errors++; end
    checks++;
    if (busy !== 1'b0) begin $display("FAIL os_idle: busy=%b want 0", busy); errors++; end
    checks++;
  endtask

  task automatic test_phasing();
    int ph_err;
    step_thresh = 32'd2; hold_high = 16'd1; hold_low = 16'd1; one_shot = 1'b0;
    offset = {16'd10, 16'd5, 16'd0};
    ph_err = 0;
    start_run();
    for (int j = 0; j <= 20 + 3 * 68; j++) begin
      adv_to(j);
      for (int c = 0; c < N_CH; c++) begin
        logic [DW-1:0] exp_d;
        exp_d = (j >= 10 * c) ? DW'(g(j - 10 * c)) : '0;
        if (duty[c*DW +: DW] !== exp_d) begin
          if (ph_err < 10)
            $display("FAIL phase ch%0d j=%0d: got %0d want %0d", c, j, duty[c*DW +: DW], exp_d);
          ph_err++;
          errors++;
        end
        checks++;
      end
    end
    en = 1'b0;
    adv_to(j_now + 1);
    if (busy !== 1'b0 || duty !== '0) begin
      $display("FAIL phase_stop: busy=%b duty=%0h want 0 0", busy, duty); errors++;
    end
    checks++;
  endtask

  task automatic test_abort();
    int base;
    step_thresh = 32'd1; hold_high = 16'd1; hold_low = 16'd1; offset = '0; one_shot = 1'b0;
    base = done_cnt;
    start_run();
    adv_to(7);
    if (duty !== rep3(6)) begin $display("FAIL abort_pre6: got %0h want %0h", duty, rep3(6)); errors++; end
    checks++;
    adv_to(8);
    if (duty !== rep3(7)) begin $display("FAIL abort_pre7: got %0h want %0h", duty, rep3(7)); errors++; end
    checks++;
    en = 1'b0;
    adv_to(9);
    if (duty !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      $display("FAIL abort_next: duty=%0h busy=%b done=%b want 0 0 0", duty, busy, done); errors++;
    end
    checks++;
    adv_to(13);
    if (done_cnt - base !== 0) begin $display("FAIL abort_no_done: got %0d want 0", done_cnt - base); errors++; end
    checks++;
  endtask

  task automatic test_boundaries();
    int base;
    step_thresh = 32'd0; hold_high = 16'd0; hold_low = 16'd0; offset = '0; one_shot = 1'b1;
    base = done_cnt;
    start_run();
    adv_to(1);
    if (duty !== rep3(0)) begin $display("FAIL bnd_j1: got %0h want %0h", duty, rep3(0)); errors++; end
    checks++;
    adv_to(2);
    if (duty !== rep3(1)) begin $display("FAIL bnd_j2: got %0h want %0h", duty, rep3(1)); errors++; end
    checks++;
    adv_to(17);
    if (duty !== rep3(16)) begin $display("FAIL bnd_j17: got %0h want %0h", duty, rep3(16)); errors++; end
    checks++;
    adv_to(18);
    if (duty !== rep3(16)) begin $display("FAIL bnd_j18: got %0h want %0h", duty, rep3(16)); errors++; end
    checks++;
    adv_to(19);
    if (duty !== rep3(15)) begin $display("FAIL bnd_j19: got %0h want %0h", duty, rep3(15)); errors++; end
    checks++;
    adv_to(34);
    if (duty !== rep3(0) || busy !== 1'b1) begin
      $display("FAIL bnd_j34: duty=%0h busy=%b want 0 1", duty, busy); errors++;
    end
    checks++;
    adv_to(35);
    if (busy !== 1'b0) begin $display("FAIL bnd_low_one_clk: busy=%b want 0", busy); errors++; end
    checks++;
    adv_to(36);
    if (done !== 1'b1) begin $display("FAIL bnd_done: got %b want 1", done); errors++; end
    checks++;
    en = 1'b0;
    adv_to(39);
    if (done_cnt - base !== 1) begin $display("FAIL bnd_done_count: got %0d want 1", done_cnt - base); errors++; end
    checks++;
    if (ovf !== 1'b0) begin $display("FAIL bnd_no_overflow: flag=%b want 0", ovf); errors++; end
    checks++;
  endtask

  task automatic test_back_to_back();
    step_thresh = 32'd1; hold_high = 16'd2; hold_low = 16'd0; offset = '0; one_shot = 1'b1;
    start_run();
    adv_to(5);
    hold_high = 16'd9;
    adv_to(17);
    if (duty !== rep3(16)) begin $display("FAIL cfg_j17: got %0h want %0h", duty, rep3(16)); errors++; end
    checks++;
    for (int k = 18; k <= 19; k++) begin
      adv_to(k);
      if (duty !== rep3(16) || pwm_out !== 3'b111) begin
        $display("FAIL cfg_hold j=%0d: duty=%0h pwm=%b want %0h 111", k, duty, pwm_out, rep3(16)); errors++;
      end
      checks++;
    end
    adv_to(20);
    if (duty !== rep3(15)) begin $display("FAIL cfg_old_hold: got %0h want %0h", duty, rep3(15)); errors++; end
    checks++;
    adv_to(36);
    if (busy !== 1'b0 || done !== 1'b0) begin
      $display("FAIL cfg_end: busy=%b done=%b want 0 0", busy, done); errors++;
    end
    checks++;
    adv_to(37);
    if (done !== 1'b1) begin $display("FAIL cfg_done: got %b want 1", done); errors++; end
    checks++;
    adv_to(38);
    if (busy !== 1'b1 || done !== 1'b0) begin
      $display("FAIL cfg_restart: busy=%b done=%b want 1 0", busy, done); errors++;
    end
    checks++;
    adv_to(38 + 26);
    if (duty !== rep3(16)) begin $display("FAIL cfg_new_hold16: got %0h want %0h", duty, rep3(16)); errors++; end
    checks++;
    adv_to(38 + 27);
    if (duty !== rep3(15)) begin $display("FAIL cfg_new_hold15: got %0h want %0h", duty, rep3(15)); errors++; end
    checks++;
    en = 1'b0;
    adv_to(j_now + 1);
    if (busy !== 1'b0) begin $display("FAIL cfg_stop: busy=%b want 0", busy); errors++; end
    checks++;
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_phasing();
    test_abort();
    test_boundaries();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
